touch_event_decoder: RTL and testbench

TOUCH_EVENT_DECODER -- requirements
Module: touch_event_decoder

---
 rtl/touch_pkg.sv | 32 +++
 rtl/touch_event_decoder_if.sv | 35 +++
 rtl/touch_region_lut.sv | 57 +++++
 rtl/touch_event_decoder.sv | 150 +++++++++++++++
 tb/tb_touch_event_decoder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/touch_pkg.sv
// Shared types for the touch event decoder: FSM state encodings, panel size and region record.
package touch_pkg;

  localparam int unsigned H_ACT   = 1024;
  localparam int unsigned V_ACT   = 600;
  localparam int unsigned COORD_W = 32;
  localparam int unsigned PAGE_W  = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DEBOUNCE = 3'd1;
  localparam state_t ST_PRESSED  = 3'd2;
  localparam state_t ST_LONG     = 3'd3;
  localparam state_t ST_WAIT_REL = 3'd4;

  // Coordinates are stored zero-extended so the record is independent of the port width.
  typedef struct packed {
    logic                en;
    logic [PAGE_W-1:0]   page;
    logic [COORD_W-1:0]  x0;
    logic [COORD_W-1:0]  x1;
    logic [COORD_W-1:0]  y0;
    logic [COORD_W-1:0]  y1;
  } region_t;

  function automatic logic region_hit(input region_t r, input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y, input logic [PAGE_W-1:0] page);
    return r.en && (r.page == page) && (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
  endfunction

endpackage

// File: rtl/touch_event_decoder_if.sv
// Touch panel, region-configuration and event signals of the touch event decoder.
interface touch_event_decoder_if #(
  parameter int unsigned N_BTN = 16,
  parameter int unsigned CW    = 16
);
  localparam int unsigned IDW = $clog2(N_BTN);

  logic             touch_valid;
  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic [2:0]       page;
  logic             cfg_we;
  logic [IDW-1:0]   cfg_idx;
  logic [CW-1:0]    cfg_x0;
  logic [CW-1:0]    cfg_x1;
  logic [CW-1:0]    cfg_y0;
  logic [CW-1:0]    cfg_y1;
  logic [2:0]       cfg_page;
  logic             cfg_en;
  logic [N_BTN-1:0] click;
  logic [N_BTN-1:0] long_press;
  logic             held;
  logic [IDW-1:0]   btn_id;

  modport master (
    output touch_valid, x, y, page, cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_page, cfg_en,
    input  click, long_press, held, btn_id
  );

  modport slave (
    input  touch_valid, x, y, page, cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_page, cfg_en,
    output click, long_press, held, btn_id
  );

endinterface

// File: rtl/touch_region_lut.sv
// Region table registers plus lowest-index-wins hit encoder, registered outputs.
module touch_region_lut
  import touch_pkg::*;
#(
  parameter int unsigned N_BTN = 16,
  parameter int unsigned IDW   = $clog2(N_BTN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [PAGE_W-1:0]  page,
  input  logic               cfg_we,
  input  logic [IDW-1:0]     cfg_idx,
  input  region_t            cfg_rec,
  output logic               hit,
  output logic [IDW-1:0]     id
);

  region_t        region_q [N_BTN];
  region_t        region_d [N_BTN];
  logic           hit_d, hit_q;
  logic [IDW-1:0] id_d, id_q;

  always_comb begin
    hit_d = 1'b0;
    id_d  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      region_d[k] = region_q[k];
      if (cfg_we && (cfg_idx == IDW'(k))) region_d[k] = cfg_rec;
    end
    // Descending scan so the lowest matching index is the one left standing.
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (touch_valid && region_hit(region_q[k], x, y, page)) begin
        hit_d = 1'b1;
        id_d  = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_BTN; k++) region_q[k] <= '0;
      hit_q <= 1'b0;
      id_q  <= '0;
    end else begin
      for (int k = 0; k < N_BTN; k++) region_q[k] <= region_d[k];
      hit_q <= hit_d;
      id_q  <= id_d;
    end
  end

  assign hit = hit_q;
  assign id  = id_q;

endmodule

// File: rtl/touch_event_decoder.sv
// Debounced touch-region decoder producing click, long-press and held indications.
module touch_event_decoder
  import touch_pkg::*;
#(
  parameter int unsigned N_BTN    = 16,
  parameter int unsigned CW       = 16,
  parameter int unsigned DEB_CYC  = 50000,
  parameter int unsigned LONG_CYC = 25000000
) (
  input logic                  clk,
  input logic                  reset,
  touch_event_decoder_if.slave bus
);

  localparam int unsigned IDW     = $clog2(N_BTN);
  localparam int unsigned MAX_CYC = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned REL_W   = $clog2(DEB_CYC + 1);

  region_t          cfg_rec;
  logic             hit;
  logic [IDW-1:0]   hit_id;
  state_t           state_d, state_q;
  logic [IDW-1:0]   id_d, id_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic [REL_W-1:0] rel_d, rel_q, rel_inc;
  logic [N_BTN-1:0] click_d, click_q, long_d, long_q;
  logic             held_d, held_q;
  logic [IDW-1:0]   btn_id_d, btn_id_q;
  logic             present, lost_done;

  always_comb begin
    cfg_rec      = '0;
    cfg_rec.en   = bus.cfg_en;
    cfg_rec.page = bus.cfg_page;
    cfg_rec.x0   = COORD_W'(bus.cfg_x0);
    cfg_rec.x1   = COORD_W'(bus.cfg_x1);
    cfg_rec.y0   = COORD_W'(bus.cfg_y0);
    cfg_rec.y1   = COORD_W'(bus.cfg_y1);
  end

  touch_region_lut #(.N_BTN(N_BTN), .IDW(IDW)) u_lut (
    .clk         (clk),
    .reset       (reset),
    .touch_valid (bus.touch_valid),
    .x           (COORD_W'(bus.x)),
    .y           (COORD_W'(bus.y)),
    .page        (bus.page),
    .cfg_we      (bus.cfg_we),
    .cfg_idx     (bus.cfg_idx),
    .cfg_rec     (cfg_rec),
    .hit         (hit),
    .id          (hit_id)
  );

  // Page change, disabled region or sliding away all show up as the captured id no longer hitting.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    click_d   = '0;
    long_d    = '0;
    present   = hit && (hit_id == id_q);
    lost_done = !present && (rel_q == REL_W'(DEB_CYC - 1));
    cnt_inc   = (cnt_q == CNT_W'(MAX_CYC)) ? cnt_q : cnt_q + CNT_W'(1);
    rel_inc   = (rel_q == REL_W'(DEB_CYC)) ? rel_q : rel_q + REL_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_DEBOUNCE;
          id_d    = hit_id;
          cnt_d   = '0;
          rel_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!present) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          rel_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        cnt_d = cnt_inc;
        rel_d = present ? REL_W'(0) : rel_inc;
        if (lost_done) begin
          click_d = N_BTN'(1) << id_q;
          state_d = bus.touch_valid ? ST_WAIT_REL : ST_IDLE;
          rel_d   = '0;
        end else if (cnt_q == CNT_W'(LONG_CYC - 1)) begin
          long_d  = N_BTN'(1) << id_q;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        rel_d = present ? REL_W'(0) : rel_inc;
        if (lost_done) begin
          state_d = ST_WAIT_REL;
          rel_d   = '0;
        end
      end
      ST_WAIT_REL: begin
        rel_d = bus.touch_valid ? REL_W'(0) : rel_inc;
        if (!bus.touch_valid && (rel_q == REL_W'(DEB_CYC - 1))) begin
          state_d = ST_IDLE;
          rel_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    held_d   = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    btn_id_d = held_d ? id_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      cnt_q    <= '0;
      rel_q    <= '0;
      click_q  <= '0;
      long_q   <= '0;
      held_q   <= 1'b0;
      btn_id_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      click_q  <= click_d;
      long_q   <= long_d;
      held_q   <= held_d;
      btn_id_q <= btn_id_d;
    end
  end

  assign bus.click      = click_q;
  assign bus.long_press = long_q;
  assign bus.held       = held_q;
  assign bus.btn_id     = btn_id_q;

endmodule

// File: tb/tb_touch_event_decoder.sv
// Directed bench for touch_event_decoder: debounce, priority, long press, boundaries, slide and reset.
module tb_touch_event_decoder;
  import touch_pkg::*;

  localparam int unsigned N_BTN = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEB   = 20;
  localparam int unsigned LONG  = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  touch_event_decoder_if #(.N_BTN(N_BTN), .CW(CW)) bus ();

  touch_event_decoder #(.N_BTN(N_BTN), .CW(CW), .DEB_CYC(DEB), .LONG_CYC(LONG)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned click_tot = 0;
  int unsigned long_tot = 0;
  int unsigned pulse_err = 0;
  int unsigned last_click_cyc = 0;
  int unsigned click_cnt [N_BTN] = '{default: 0};
  int unsigned long_cnt  [N_BTN] = '{default: 0};

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if ((bus.click != '0) && (bus.long_press != '0)) pulse_err++;
      if (($countones(bus.click) > 1) || ($countones(bus.long_press) > 1)) pulse_err++;
      for (int k = 0; k < N_BTN; k++) begin
        if (bus.click[k]) begin
          click_cnt[k]++;
          click_tot++;
          last_click_cyc = cyc;
        end
        if (bus.long_press[k]) begin
          long_cnt[k]++;
          long_tot++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int unsigned idx, input int unsigned x0, input int unsigned x1,
                     input int unsigned y0, input int unsigned y1, input int unsigned pg, input logic en);
    bus.cfg_idx  = 4'(idx);
    bus.cfg_x0   = 16'(x0);
    bus.cfg_x1   = 16'(x1);
    bus.cfg_y0   = 16'(y0);
    bus.cfg_y1   = 16'(y1);
    bus.cfg_page = 3'(pg);
    bus.cfg_en   = en;
    bus.cfg_we   = 1'b1;
    step(1);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic touch(input int unsigned px, input int unsigned py);
    bus.x = 16'(px);
    bus.y = 16'(py);
    bus.touch_valid = 1'b1;
  endtask

  int unsigned t0, base_tot, base3, base2, base5;

  initial begin
    bus.touch_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.page = 3'd0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_x0 = '0;
    bus.cfg_x1 = '0;
    bus.cfg_y0 = '0;
    bus.cfg_y1 = '0;
    bus.cfg_page = '0;
    bus.cfg_en = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_click", 32'(bus.click), 32'd0);
    chk("rst_long", 32'(bus.long_press), 32'd0);
    chk("rst_held", 32'(bus.held), 32'd0);
    chk("rst_btn_id", 32'(bus.btn_id), 32'd0);
    chk("rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    step(3);
    reset = 1'b1;
    step(2);

    // Unconfigured table: no region may match.
    touch(100, 300);
    step(DEB + 10);
    chk("unconfigured_held", 32'(bus.held), 32'd0);
    bus.touch_valid = 1'b0;
    step(5);

    // Short press on region 3.
    cfg(3, 75, 315, 200, 448, 0, 1'b1);
    touch(100, 300);
    step(DEB / 2);
    chk("a_debounce_held", 32'(bus.held), 32'd0);
    step(DEB / 2 + 10);
    chk("a_held", 32'(bus.held), 32'd1);
    chk("a_btn_id", 32'(bus.btn_id), 32'd3);
    chk("a_state", 32'(u_dut.state_q), 32'(ST_PRESSED));
    t0 = cyc;
    bus.touch_valid = 1'b0;
    step(DEB / 2);
    chk("a_held_in_release", 32'(bus.held), 32'd1);
    chk("a_no_early_click", click_tot, 32'd0);
    step(DEB);
    chk("a_click3", click_cnt[3], 32'd1);
    chk("a_click_tot", click_tot, 32'd1);
    chk("a_click_delay", 32'((last_click_cyc - t0 >= DEB) && (last_click_cyc - t0 <= DEB + 4)), 32'd1);
    chk("a_state_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
    chk("a_held_low", 32'(bus.held), 32'd0);

    // Touch shorter than debounce.
    base_tot = click_tot;
    touch(100, 300);
    step(DEB / 2);
    bus.touch_valid = 1'b0;
    step(2 * DEB);
    chk("b_no_click", click_tot - base_tot, 32'd0);
    chk("b_state_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
    chk("b_held", 32'(bus.held), 32'd0);

    // Overlapping regions 2 and 5 with region 3: lowest index wins.
    cfg(2, 50, 200, 250, 350, 0, 1'b1);
    cfg(5, 90, 120, 280, 320, 0, 1'b1);
    base_tot = click_tot; base2 = click_cnt[2]; base3 = click_cnt[3]; base5 = click_cnt[5];
    touch(100, 300);
    step(DEB + 10);
    chk("c_btn_id", 32'(bus.btn_id), 32'd2);
    bus.touch_valid = 1'b0;
    step(DEB + 10);
    chk("c_click2", click_cnt[2] - base2, 32'd1);
    chk("c_click3", click_cnt[3] - base3, 32'd0);
    chk("c_click5", click_cnt[5] - base5, 32'd0);
    chk("c_click_tot", click_tot - base_tot, 32'd1);

    // Long press on region 3 (region 2 disabled).
    cfg(2, 50, 200, 250, 350, 0, 1'b0);
    base_tot = click_tot;
    touch(100, 300);
    step(DEB + LONG + 20);
    chk("d_long3", long_cnt[3], 32'd1);
    chk("d_state_long", 32'(u_dut.state_q), 32'(ST_LONG));
    chk("d_held", 32'(bus.held), 32'd1);
    step(200);
    chk("d_single_long", long_tot, 32'd1);
    bus.touch_valid = 1'b0;
    step(DEB + 8);
    chk("d_wait_rel", 32'(u_dut.state_q), 32'(ST_WAIT_REL));
    chk("d_wait_held", 32'(bus.held), 32'd0);
    step(DEB + 10);
    chk("d_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
    chk("d_no_click", click_tot - base_tot, 32'd0);

    // Boundary corner hits; one past misses; wrong page misses.
    base3 = click_cnt[3];
    touch(315, 448);
    step(DEB + 10);
    chk("e_corner_held", 32'(bus.held), 32'd1);
    chk("e_corner_id", 32'(bus.btn_id), 32'd3);
    bus.touch_valid = 1'b0;
    step(DEB + 10);
    chk("e_corner_click", click_cnt[3] - base3, 32'd1);
    base_tot = click_tot;
    touch(316, 448);
    step(DEB + 10);
    chk("e_x316_held", 32'(bus.held), 32'd0);
    chk("e_x316_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    bus.touch_valid = 1'b0;
    step(5);
    bus.page = 3'd1;
    touch(100, 300);
    step(DEB + 10);
    chk("e_page_held", 32'(bus.held), 32'd0);
    bus.touch_valid = 1'b0;
    bus.page = 3'd0;
    step(DEB + 10);
    chk("e_miss_no_click", click_tot - base_tot, 32'd0);

    // Slide from region 3 onto region 6 counts as a release of 3.
    cfg(6, 400, 500, 100, 150, 0, 1'b1);
    base_tot = click_tot; base3 = click_cnt[3];
    touch(100, 300);
    step(DEB + 10);
    chk("f_held", 32'(bus.held), 32'd1);
    touch(450, 120);
    step(DEB + 8);
    chk("f_click3", click_cnt[3] - base3, 32'd1);
    chk("f_click_tot", click_tot - base_tot, 32'd1);
    chk("f_wait_rel", 32'(u_dut.state_q), 32'(ST_WAIT_REL));
    step(DEB + 10);
    chk("f_no_retrigger", 32'(bus.held), 32'd0);
    bus.touch_valid = 1'b0;
    step(2 * DEB + 10);
    chk("f_idle", 32'(u_dut.state_q), 32'(ST_IDLE));

    // Reset mid-press drops the press with no pulse.
    touch(100, 300);
    step(DEB + 10);
    chk("g_held", 32'(bus.held), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("g_rst_held", 32'(bus.held), 32'd0);
    chk("g_rst_btn_id", 32'(bus.btn_id), 32'd0);
    chk("g_rst_click", 32'(bus.click), 32'd0);
    chk("g_rst_long", 32'(bus.long_press), 32'd0);
    base_tot = click_tot;
    step(3);
    reset = 1'b1;
    step(DEB + 10);
    bus.touch_valid = 1'b0;
    step(2 * DEB + 10);
    chk("g_no_click", click_tot - base_tot, 32'd0);
    chk("g_held_after", 32'(bus.held), 32'd0);

    chk("pulse_exclusive_onehot", pulse_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
